midpoint_pager: RTL and testbench

- Parametrised successor to the lab SPI midpoint datapath.
- Conditions the raw board inputs: two-flop synchroniser, debounce and edge pulses on every switch and button.
- Drives a WIDTH-bit serial-in/parallel-out shift register with a parallel-load preset.
- Shows the register on the 4 LEDs as a selectable 4-bit page, stepped with buttons; this replaces the fixed low-nibble display.

---
 rtl/midpoint_pager_pkg.sv | 11 +
 rtl/midpoint_pager_input_conditioner.sv | 50 +++++
 rtl/midpoint_pager.sv | 86 ++++++++
 tb/tb_midpoint_pager.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/midpoint_pager_pkg.sv
// Shared width utilities for the midpoint pager block.
package midpoint_pager_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/midpoint_pager_input_conditioner.sv
// Two-flop synchroniser plus debounce filter; emits the accepted level and
// single-cycle pulses on each accepted rising and falling transition.
module input_conditioner
  import midpoint_pager_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic noisysignal,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge
);

  localparam int CNT_W = (DEBOUNCE > 1) ? clog2(DEBOUNCE) : 1;

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // A new level is accepted only after s2 has disagreed with the current
  // level for DEBOUNCE consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      cnt          <= '0;
      conditioned  <= 1'b0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end else begin
      s1           <= noisysignal;
      s2           <= s1;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
      if (s2 == conditioned) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
        conditioned  <= s2;
        cnt          <= '0;
        positiveedge <= s2;
        negativeedge <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/midpoint_pager.sv
// Board-input front end driving a serial-in/parallel-out shift register whose
// contents are viewed on four LEDs one nibble page at a time.
module midpoint_pager
  import midpoint_pager_pkg::*;
#(
  parameter  int               WIDTH    = 8,
  parameter  logic [WIDTH-1:0] LOAD_VAL = 'hA5,
  parameter  int               DEBOUNCE = 3,
  localparam int               NPAGES   = WIDTH / 4,
  localparam int               PAGE_W   = (NPAGES > 1) ? clog2(NPAGES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        sw,
  input  logic [2:0]        btn,
  output logic [3:0]        led,
  output logic [WIDTH-1:0]  par_out,
  output logic [PAGE_W-1:0] page
);

  logic [2:0] btn_pos;
  logic [2:0] btn_cond_unused;
  logic [2:0] btn_neg_unused;
  logic       data_cond;
  logic       data_pos_unused;
  logic       data_neg_unused;
  logic       sclk_cond_unused;
  logic       sclk_pos;
  logic       sclk_neg_unused;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    input_conditioner #(.DEBOUNCE(DEBOUNCE)) u_cond (
      .clk          (clk),
      .reset        (reset),
      .noisysignal  (btn[i]),
      .conditioned  (btn_cond_unused[i]),
      .positiveedge (btn_pos[i]),
      .negativeedge (btn_neg_unused[i])
    );
  end

  // Falling-edge pulses are left dangling for the future MISO stage.
  input_conditioner #(.DEBOUNCE(DEBOUNCE)) u_data (
    .clk          (clk),
    .reset        (reset),
    .noisysignal  (sw[0]),
    .conditioned  (data_cond),
    .positiveedge (data_pos_unused),
    .negativeedge (data_neg_unused)
  );

  input_conditioner #(.DEBOUNCE(DEBOUNCE)) u_sclk (
    .clk          (clk),
    .reset        (reset),
    .noisysignal  (sw[1]),
    .conditioned  (sclk_cond_unused),
    .positiveedge (sclk_pos),
    .negativeedge (sclk_neg_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      par_out <= '0;
    end else if (btn_pos[0]) begin
      par_out <= LOAD_VAL;
    end else if (sclk_pos) begin
      par_out <= {par_out[WIDTH-2:0], data_cond};
    end
  end

  // Simultaneous up and down presses cancel; both directions wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      page <= '0;
    end else if (btn_pos[2] && !btn_pos[1]) begin
      page <= (page == PAGE_W'(NPAGES - 1)) ? '0 : page + 1'b1;
    end else if (btn_pos[1] && !btn_pos[2]) begin
      page <= (page == '0) ? PAGE_W'(NPAGES - 1) : page - 1'b1;
    end
  end

  always_comb begin
    led = par_out[{page, 2'b00} +: 4];
  end

endmodule

// File: tb/tb_midpoint_pager.sv
// Scoreboard bench for midpoint_pager: stimulus queues timed expectations from
// an event-level model, a negedge monitor pops and compares them.
module tb_midpoint_pager;

  localparam int          WIDTH = 16;
  localparam logic [15:0] LOAD  = 16'hA5C3;
  localparam int          DEB   = 3;
  localparam int          NP    = WIDTH / 4;

  logic        clk;
  logic        reset;
  logic [1:0]  sw;
  logic [2:0]  btn;
  logic [3:0]  led;
  logic [15:0] par_out;
  logic [1:0]  page;

  typedef struct {
    int          cycle;
    logic [15:0] par;
    logic [1:0]  pg;
    logic [3:0]  ledv;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  logic [15:0] par_m;
  int          page_m;
  logic [4:0]  raw_m;

  midpoint_pager #(.WIDTH(WIDTH), .LOAD_VAL(LOAD), .DEBOUNCE(DEB)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw      (sw),
    .btn     (btn),
    .led     (led),
    .par_out (par_out),
    .page    (page)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [3:0] ledOf(input logic [15:0] p, input int pg);
    logic [15:0] tmp;
    tmp = p >> (4 * pg);
    return tmp[3:0];
  endfunction

  task automatic drive(input logic [4:0] r);
    btn = r[2:0];
    sw  = r[4:3];
  endtask

  task automatic pushModel(input int at, input string tag);
    exp_t e;
    e.cycle = at;
    e.par   = par_m;
    e.pg    = 2'(page_m);
    e.ledv  = ledOf(par_m, page_m);
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic expectConst(input logic [15:0] p, input logic [1:0] pg,
                             input logic [3:0] l, input string tag);
    exp_t e;
    e.cycle = cyc + 1;
    e.par   = p;
    e.pg    = pg;
    e.ledv  = l;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (par_out !== e.par || page !== e.pg || led !== e.ledv) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d got par=%h page=%0d led=%h expected par=%h page=%0d led=%h",
               e.tag, cyc, par_out, page, led, e.par, e.pg, e.ledv);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cycle <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cycle < cyc) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s stale entry for cyc=%0d seen at %0d", mon_e.tag, mon_e.cycle, cyc);
      end else begin
        checkOutput(mon_e);
      end
    end
  end

  // Drive a new raw level, hold it, switch to 'after', then let things settle.
  // An input change is accepted when held for at least DEB sampled cycles and
  // then takes effect on par_out/page six edges after it was first driven.
  task automatic applyStimulus(input logic [4:0] lvl, input int hold,
                               input logic [4:0] after, input int settle,
                               input string tag);
    logic [4:0] acc;
    logic [4:0] rise;
    logic       ser;
    int         c;
    @(negedge clk);
    c = cyc;
    pushModel(c + 5, {tag, "_before"});
    drive(lvl);
    acc  = (hold >= DEB) ? (raw_m ^ lvl) : 5'b0;
    rise = acc & lvl;
    ser  = acc[3] ? lvl[3] : raw_m[3];
    if (rise[0])      par_m = LOAD;
    else if (rise[4]) par_m = {par_m[14:0], ser};
    if (rise[2] && !rise[1])      page_m = (page_m + 1) % NP;
    else if (rise[1] && !rise[2]) page_m = (page_m + NP - 1) % NP;
    pushModel(c + 6, {tag, "_after"});
    repeat (hold) @(negedge clk);
    drive(after);
    raw_m = after;
    repeat (settle) @(negedge clk);
    pushModel(cyc + 1, {tag, "_settled"});
  endtask

  task automatic doReset();
    int c;
    @(negedge clk);
    reset = 1'b1;
    drive(5'($urandom));
    par_m  = '0;
    page_m = 0;
    raw_m  = '0;
    pushModel(cyc + 1, "reset_held1");
    pushModel(cyc + 2, "reset_held2");
    @(negedge clk);
    drive(5'($urandom));
    @(negedge clk);
    reset = 1'b0;
    drive(5'b0);
    c = cyc;
    pushModel(c + 1, "reset_first_edge");
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [4:0] lvl;
    logic [4:0] aft;
    int         kind;
    int         b;
    reset  = 1'b1;
    sw     = '0;
    btn    = '0;
    par_m  = '0;
    page_m = 0;
    raw_m  = '0;
    repeat (2) @(negedge clk);

    doReset();
    expectConst(16'h0000, 2'd0, 4'h0, "reset_const");

    applyStimulus(5'b00001, 2, 5'b00000, 7, "glitch_btn0");
    expectConst(16'h0000, 2'd0, 4'h0, "glitch_btn0_const");
    applyStimulus(5'b10000, 2, 5'b00000, 7, "glitch_sw1");
    expectConst(16'h0000, 2'd0, 4'h0, "glitch_sw1_const");

    applyStimulus(5'b00001, 8, 5'b00000, 8, "load");
    expectConst(16'hA5C3, 2'd0, 4'h3, "load_const");

    applyStimulus(5'b01000, 6, 5'b01000, 2, "sw0_hi");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'b11000, 6, 5'b11000, 1, "shift1_rise");
      applyStimulus(5'b01000, 6, 5'b01000, 1, "shift1_fall");
    end
    expectConst(16'h5C3F, 2'd0, 4'hF, "shift4_const");
    applyStimulus(5'b00000, 6, 5'b00000, 2, "sw0_lo");
    applyStimulus(5'b10000, 6, 5'b10000, 1, "shift0_rise");
    applyStimulus(5'b00000, 6, 5'b00000, 2, "shift0_fall");
    expectConst(16'hB87E, 2'd0, 4'hE, "shift5_const");

    applyStimulus(5'b00001, 6, 5'b00000, 8, "reload");
    for (int i = 0; i < 3; i++) applyStimulus(5'b00100, 6, 5'b00000, 8, "page_up");
    expectConst(16'hA5C3, 2'd3, 4'hA, "page3_const");
    applyStimulus(5'b00100, 6, 5'b00000, 8, "page_wrap_up");
    expectConst(16'hA5C3, 2'd0, 4'h3, "page_wrap_const");
    applyStimulus(5'b00010, 6, 5'b00000, 8, "page_wrap_down");
    expectConst(16'hA5C3, 2'd3, 4'hA, "page_down_const");
    applyStimulus(5'b00110, 6, 5'b00000, 8, "page_both");
    expectConst(16'hA5C3, 2'd3, 4'hA, "page_both_const");

    applyStimulus(5'b01000, 6, 5'b01000, 2, "sw0_hi2");
    applyStimulus(5'b11000, 6, 5'b11000, 1, "pre_shift_rise");
    applyStimulus(5'b01000, 6, 5'b01000, 2, "pre_shift_fall");
    applyStimulus(5'b11001, 6, 5'b11000, 8, "load_and_shift");
    expectConst(16'hA5C3, 2'd3, 4'hA, "load_prio_const");
    applyStimulus(5'b01000, 6, 5'b01000, 2, "sw1_release");

    @(negedge clk);
    drive(raw_m | 5'b00001);
    repeat (2) @(negedge clk);
    doReset();
    repeat (8) @(negedge clk);
    expectConst(16'h0000, 2'd0, 4'h0, "reset_mid_debounce_const");

    for (int n = 0; n < 70; n++) begin
      kind = $urandom_range(0, 8);
      case (kind)
        0: applyStimulus(raw_m | 5'b00001, $urandom_range(DEB, 8), raw_m, 7, "rnd_load");
        1: begin
          lvl = raw_m;
          lvl[3] = 1'($urandom);
          applyStimulus(lvl, 6, lvl, 1, "rnd_sw0");
        end
        2: begin
          lvl = raw_m ^ 5'b10000;
          applyStimulus(lvl, $urandom_range(6, 8), lvl, 1, "rnd_sw1");
        end
        3: applyStimulus(raw_m | 5'b00100, $urandom_range(DEB, 8), raw_m, 7, "rnd_up");
        4: applyStimulus(raw_m | 5'b00010, $urandom_range(DEB, 8), raw_m, 7, "rnd_down");
        5: applyStimulus(raw_m | 5'b00110, $urandom_range(DEB, 8), raw_m, 7, "rnd_both");
        6: begin
          b = $urandom_range(0, 4);
          lvl = raw_m ^ (5'b00001 << b);
          applyStimulus(lvl, $urandom_range(1, DEB - 1), raw_m, 7, "rnd_glitch");
        end
        7: begin
          if (!raw_m[4]) begin
            lvl = raw_m | 5'b10001;
            aft = raw_m | 5'b10000;
            applyStimulus(lvl, 6, aft, 7, "rnd_load_shift");
          end else begin
            applyStimulus(raw_m | 5'b00001, 6, raw_m, 7, "rnd_load_only");
          end
        end
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            doReset();
            applyStimulus(raw_m, 1, raw_m, 7, "rnd_post_reset");
          end else begin
            applyStimulus(raw_m, 1, raw_m, 7, "rnd_idle");
          end
        end
      endcase
    end

    for (int w = 0; w < 40 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain %0d expectations left unchecked, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
